instr_decoder: RTL and testbench



---
 rtl/instr_decoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_instr_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
//
// Single-stage decoder for a small RV32 subset: ADDI, ADD, BEQ and JAL.
// Every other encoding is reported as ILLEGAL with all register and immediate
// fields forced to zero. Each decoded record is captured in one output
// register behind a valid/ready handshake. That register is refilled on the
// same edge that drains it, so a record can move through on every cycle.
//
// Also keeps one wrapping counter per instruction class. A counter advances
// only when an instruction is accepted on the input side.
//
// Parameters
//   DATA_WIDTH  instruction / PC / immediate width (32 or more)
//   DIR_WIDTH   register address width
//   CNT_WIDTH   per-class counter width
//
// Ports
//   clk            rising-edge clock
//   arst           asynchronous active-high reset
//   in_valid       upstream offers in_instr / in_pc
//   in_ready       decoder accepts this cycle (combinational)
//   in_instr       raw RV32 instruction word
//   in_pc          address of in_instr
//   out_valid      output register holds a decoded record
//   out_ready      downstream consumes the record
//   out_kind       0=ADDI 1=ADD 2=BEQ 3=JAL 4=ILLEGAL
//   out_rd/rs1/rs2 register fields
//   out_imm        sign-extended immediate
//   out_reg_write  instruction writes a non-zero rd
//   out_target     pc+imm for BEQ/JAL, pc+4 otherwise
//   out_link       pc+4
//   cnt_*          accepted-instruction count per class
// -----------------------------------------------------------------------------
module instr_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int DIR_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_kind,
  output logic [DIR_WIDTH-1:0]  out_rd,
  output logic [DIR_WIDTH-1:0]  out_rs1,
  output logic [DIR_WIDTH-1:0]  out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_reg_write,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic [DATA_WIDTH-1:0] out_link,
  output logic [CNT_WIDTH-1:0]  cnt_addi,
  output logic [CNT_WIDTH-1:0]  cnt_add,
  output logic [CNT_WIDTH-1:0]  cnt_beq,
  output logic [CNT_WIDTH-1:0]  cnt_jal,
  output logic [CNT_WIDTH-1:0]  cnt_illegal
);

  // Instruction class codes presented on out_kind
  localparam logic [2:0] KIND_ADDI    = 3'd0;
  localparam logic [2:0] KIND_ADD     = 3'd1;
  localparam logic [2:0] KIND_BEQ     = 3'd2;
  localparam logic [2:0] KIND_JAL     = 3'd3;
  localparam logic [2:0] KIND_ILLEGAL = 3'd4;

  // Major opcodes of the supported subset
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ZERO = 3'b000;
  localparam logic [6:0] F7_ZERO = 7'b0000000;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  // ---------------------------------------------------------------------------
  // Raw instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;
  logic [4:0] rs1_field;
  logic [4:0] rs2_field;

  assign opcode    = in_instr[6:0];
  assign rd_field  = in_instr[11:7];
  assign funct3    = in_instr[14:12];
  assign rs1_field = in_instr[19:15];
  assign rs2_field = in_instr[24:20];
  assign funct7    = in_instr[31:25];

  // Immediates for each format, sign-extended from bit 31. B and J offsets
  // are scrambled in the encoding and always have an implicit zero LSB.
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] imm_j;

  assign imm_i = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{(DATA_WIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Combinational decode of the offered instruction
  // ---------------------------------------------------------------------------
  logic [2:0]            dec_kind;
  logic [DIR_WIDTH-1:0]  dec_rd;
  logic [DIR_WIDTH-1:0]  dec_rs1;
  logic [DIR_WIDTH-1:0]  dec_rs2;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_reg_write;
  logic                  dec_uses_offset;
  logic [DATA_WIDTH-1:0] dec_target;
  logic [DATA_WIDTH-1:0] dec_link;

  // Defaults describe the ILLEGAL record. Only a fully matching encoding
  // overrides them, which keeps every field zero for unknown words.
  always_comb begin
    dec_kind = KIND_ILLEGAL;
    dec_rd   = '0;
    dec_rs1  = '0;
    dec_rs2  = '0;
    dec_imm  = '0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ZERO) begin
          dec_kind = KIND_ADDI;
          dec_rd   = DIR_WIDTH'(rd_field);
          dec_rs1  = DIR_WIDTH'(rs1_field);
          dec_imm  = imm_i;
        end
      end
      OP_REG: begin
        if ((funct3 == F3_ZERO) && (funct7 == F7_ZERO)) begin
          dec_kind = KIND_ADD;
          dec_rd   = DIR_WIDTH'(rd_field);
          dec_rs1  = DIR_WIDTH'(rs1_field);
          dec_rs2  = DIR_WIDTH'(rs2_field);
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_ZERO) begin
          dec_kind = KIND_BEQ;
          dec_rs1  = DIR_WIDTH'(rs1_field);
          dec_rs2  = DIR_WIDTH'(rs2_field);
          dec_imm  = imm_b;
        end
      end
      OP_JAL: begin
        dec_kind = KIND_JAL;
        dec_rd   = DIR_WIDTH'(rd_field);
        dec_imm  = imm_j;
      end
      default: begin
      end
    endcase
  end

  // Writes to x0 are architecturally discarded, so they do not count as a write
  assign dec_reg_write = ((dec_kind == KIND_ADDI) || (dec_kind == KIND_ADD) ||
                          (dec_kind == KIND_JAL)) && (dec_rd != '0);

  // Address arithmetic simply wraps at the data width
  assign dec_uses_offset = (dec_kind == KIND_BEQ) || (dec_kind == KIND_JAL);
  assign dec_link        = in_pc + PC_STEP;
  assign dec_target      = dec_uses_offset ? (in_pc + dec_imm) : dec_link;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic transfer_in;
  logic transfer_out;

  // The register can take a new record when empty or when it drains on this edge
  assign in_ready     = !out_valid || out_ready;
  assign transfer_in  = in_valid && in_ready;
  assign transfer_out = out_valid && out_ready;

  // Valid flag: a load wins over a drain so back-to-back records keep it high
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_valid <= 1'b0;
    end else if (transfer_in) begin
      out_valid <= 1'b1;
    end else if (transfer_out) begin
      out_valid <= 1'b0;
    end
  end

  // Output record register: loads only on an accepted input, otherwise holds
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_kind      <= 3'd0;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_imm       <= '0;
      out_reg_write <= 1'b0;
      out_target    <= '0;
      out_link      <= '0;
    end else if (transfer_in) begin
      out_kind      <= dec_kind;
      out_rd        <= dec_rd;
      out_rs1       <= dec_rs1;
      out_rs2       <= dec_rs2;
      out_imm       <= dec_imm;
      out_reg_write <= dec_reg_write;
      out_target    <= dec_target;
      out_link      <= dec_link;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-class statistics: one counter steps per accepted instruction, wrapping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_addi    <= '0;
      cnt_add     <= '0;
      cnt_beq     <= '0;
      cnt_jal     <= '0;
      cnt_illegal <= '0;
    end else if (transfer_in) begin
      case (dec_kind)
        KIND_ADDI: cnt_addi    <= cnt_addi + CNT_ONE;
        KIND_ADD:  cnt_add     <= cnt_add + CNT_ONE;
        KIND_BEQ:  cnt_beq     <= cnt_beq + CNT_ONE;
        KIND_JAL:  cnt_jal     <= cnt_jal + CNT_ONE;
        default:   cnt_illegal <= cnt_illegal + CNT_ONE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// -----------------------------------------------------------------------------
// tb_instr_decoder
//
// Directed bench for instr_decoder. The counters are narrowed to 4 bits so
// that the wrap from all-ones back to zero is reachable in a few cycles.
// Expected records are hand-computed. A small per-class count model and a
// scoreboard follow the handshake.
// -----------------------------------------------------------------------------
module tb_instr_decoder;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int CNT_MOD = 16;

  logic          clk;
  logic          arst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic [DW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_kind;
  logic [AW-1:0] out_rd;
  logic [AW-1:0] out_rs1;
  logic [AW-1:0] out_rs2;
  logic [DW-1:0] out_imm;
  logic          out_reg_write;
  logic [DW-1:0] out_target;
  logic [DW-1:0] out_link;
  logic [CW-1:0] cnt_addi;
  logic [CW-1:0] cnt_add;
  logic [CW-1:0] cnt_beq;
  logic [CW-1:0] cnt_jal;
  logic [CW-1:0] cnt_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_cnt[5];

  instr_decoder #(
    .DATA_WIDTH(DW),
    .DIR_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_kind     (out_kind),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_imm      (out_imm),
    .out_reg_write(out_reg_write),
    .out_target   (out_target),
    .out_link     (out_link),
    .cnt_addi     (cnt_addi),
    .cnt_add      (cnt_add),
    .cnt_beq      (cnt_beq),
    .cnt_jal      (cnt_jal),
    .cnt_illegal  (cnt_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch report tag, observed and expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".cnt_addi"},    32'(cnt_addi),    32'(mdl_cnt[0]));
    checkOutput({tag, ".cnt_add"},     32'(cnt_add),     32'(mdl_cnt[1]));
    checkOutput({tag, ".cnt_beq"},     32'(cnt_beq),     32'(mdl_cnt[2]));
    checkOutput({tag, ".cnt_jal"},     32'(cnt_jal),     32'(mdl_cnt[3]));
    checkOutput({tag, ".cnt_illegal"}, 32'(cnt_illegal), 32'(mdl_cnt[4]));
  endtask

  task automatic checkRecord(input string tag, input logic [31:0] kind, input logic [31:0] rd,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [31:0] rw,
                             input logic [31:0] target, input logic [31:0] link);
    checkOutput({tag, ".valid"},     32'(out_valid),     32'd1);
    checkOutput({tag, ".kind"},      32'(out_kind),      kind);
    checkOutput({tag, ".rd"},        32'(out_rd),        rd);
    checkOutput({tag, ".rs1"},       32'(out_rs1),       rs1);
    checkOutput({tag, ".rs2"},       32'(out_rs2),       rs2);
    checkOutput({tag, ".imm"},       out_imm,            imm);
    checkOutput({tag, ".reg_write"}, 32'(out_reg_write), rw);
    checkOutput({tag, ".target"},    out_target,         target);
    checkOutput({tag, ".link"},      out_link,           link);
    checkCounters(tag);
  endtask

  // Offer one instruction for a single edge; caller guarantees in_ready is high
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input int kind);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mdl_cnt[kind] = (mdl_cnt[kind] + 1) % CNT_MOD;
  endtask

  // Stream table: instruction, class, rd, imm
  logic [31:0] st_instr[8];
  int          st_kind[8];
  logic [31:0] st_rd[8];
  logic [31:0] st_imm[8];

  initial begin
    int sb[$];
    int idx;
    int cyc;
    int stalls;
    logic mdl_valid;
    logic acc_in;
    logic acc_out;

    st_instr[0] = 32'hFFF18293; st_kind[0] = 0; st_rd[0] = 5; st_imm[0] = 32'hFFFFFFFF;
    st_instr[1] = 32'h003100B3; st_kind[1] = 1; st_rd[1] = 1; st_imm[1] = 32'h0;
    st_instr[2] = 32'hFE000CE3; st_kind[2] = 2; st_rd[2] = 0; st_imm[2] = 32'hFFFFFFF8;
    st_instr[3] = 32'h010000EF; st_kind[3] = 3; st_rd[3] = 1; st_imm[3] = 32'h10;
    st_instr[4] = 32'hFFFFFFFF; st_kind[4] = 4; st_rd[4] = 0; st_imm[4] = 32'h0;
    st_instr[5] = 32'h00000013; st_kind[5] = 0; st_rd[5] = 0; st_imm[5] = 32'h0;
    st_instr[6] = 32'h00108093; st_kind[6] = 0; st_rd[6] = 1; st_imm[6] = 32'h1;
    st_instr[7] = 32'h010000EF; st_kind[7] = 3; st_rd[7] = 1; st_imm[7] = 32'h10;
    for (int k = 0; k < 5; k++) mdl_cnt[k] = 0;

    // Reset held across edges while an instruction is offered: nothing is taken
    arst      = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h003100B3;
    in_pc     = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.valid",    32'(out_valid), 32'd0);
    checkOutput("rst.in_ready", 32'(in_ready),  32'd1);
    checkOutput("rst.kind",     32'(out_kind),  32'd0);
    checkOutput("rst.imm",      out_imm,        32'd0);
    checkOutput("rst.target",   out_target,     32'd0);
    checkCounters("rst");
    arst     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single-instruction decode");
    applyStimulus(32'hFFF18293, 32'h0, 0);
    checkRecord("addi", 0, 5, 3, 0, 32'hFFFFFFFF, 1, 32'h4, 32'h4);
    @(posedge clk);
    #1;
    checkOutput("idle.valid", 32'(out_valid), 32'd0);

    applyStimulus(32'h003100B3, 32'h8, 1);
    checkRecord("add", 1, 1, 2, 3, 32'h0, 1, 32'hC, 32'hC);
    applyStimulus(32'hFE000CE3, 32'h100, 2);
    checkRecord("beq", 2, 0, 0, 0, 32'hFFFFFFF8, 0, 32'hF8, 32'h104);
    applyStimulus(32'h010000EF, 32'h40, 3);
    checkRecord("jal", 3, 1, 0, 0, 32'h10, 1, 32'h50, 32'h44);
    applyStimulus(32'hFFFFFFFF, 32'h200, 4);
    checkRecord("ill_ones", 4, 0, 0, 0, 32'h0, 0, 32'h204, 32'h204);
    applyStimulus(32'h403100B3, 32'h204, 4);
    checkRecord("ill_sub", 4, 0, 0, 0, 32'h0, 0, 32'h208, 32'h208);
    applyStimulus(32'h00000013, 32'h10, 0);
    checkRecord("nop_x0", 0, 0, 0, 0, 32'h0, 0, 32'h14, 32'h14);
    @(posedge clk);
    #1;

    // Back-to-back stream with a three-cycle downstream stall in the middle
    $display("[TB] stream with stall");
    mdl_valid = 1'b0;
    idx = 0;
    cyc = 0;
    stalls = 0;
    while ((idx < 8 || sb.size() > 0) && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        in_instr = st_instr[idx];
        in_pc    = 32'(idx * 4);
      end
      #1;
      checkOutput("stream.in_ready", 32'(in_ready), 32'(!mdl_valid || out_ready));
      if (!in_ready) stalls++;
      checkOutput("stream.valid", 32'(out_valid), 32'(mdl_valid));
      if (mdl_valid && sb.size() > 0) begin
        checkOutput("stream.kind", 32'(out_kind), 32'(st_kind[sb[0]]));
        checkOutput("stream.rd",   32'(out_rd),   st_rd[sb[0]]);
        checkOutput("stream.imm",  out_imm,       st_imm[sb[0]]);
      end
      acc_in  = in_valid && (!mdl_valid || out_ready);
      acc_out = mdl_valid && out_ready;
      @(posedge clk);
      #1;
      if (acc_out && sb.size() > 0) void'(sb.pop_front());
      if (acc_in) begin
        sb.push_back(idx);
        mdl_cnt[st_kind[idx]] = (mdl_cnt[st_kind[idx]] + 1) % CNT_MOD;
        idx++;
      end
      mdl_valid = acc_in || (mdl_valid && !acc_out);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream.complete", 32'((idx == 8) && (sb.size() == 0)), 32'd1);
    checkOutput("stream.stalls",   32'(stalls), 32'd3);
    checkCounters("stream");

    // Sixteen more ADDIs bring the 4-bit ADDI counter around once
    $display("[TB] counter wrap");
    for (int k = 0; k < 16; k++) applyStimulus(32'h00108093, 32'h0, 0);
    checkRecord("wrap", 0, 1, 1, 0, 32'h1, 1, 32'h4, 32'h4);

    // Hold a record under back-pressure, then reset asynchronously mid-cycle
    $display("[TB] async reset during stall");
    applyStimulus(32'h010000EF, 32'h40, 3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h003100B3;
    in_pc     = 32'h8;
    @(posedge clk);
    #1;
    checkOutput("hold.in_ready", 32'(in_ready), 32'd0);
    checkRecord("hold", 3, 1, 0, 0, 32'h10, 1, 32'h50, 32'h44);
    #2;
    arst = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) mdl_cnt[k] = 0;
    checkOutput("arst.valid",    32'(out_valid), 32'd0);
    checkOutput("arst.in_ready", 32'(in_ready),  32'd1);
    checkOutput("arst.kind",     32'(out_kind),  32'd0);
    checkOutput("arst.rd",       32'(out_rd),    32'd0);
    checkOutput("arst.target",   out_target,     32'd0);
    checkCounters("arst");
    @(posedge clk);
    #1;
    checkOutput("arst_edge.valid", 32'(out_valid), 32'd0);
    checkCounters("arst_edge");
    arst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    applyStimulus(32'h003100B3, 32'h8, 1);
    checkRecord("post_rst", 1, 1, 2, 3, 32'h0, 1, 32'hC, 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
